// File: rtl/seg_bcd_conv_pkg.sv
// Shared definitions for the segment-display BCD converter.
//   - FSM state encoding
//   - datapath widths, default conversion step count
//   - decimal overflow limit and overflow display pattern
//   - display payload struct (four nibbles + decimal points)
package seg_bcd_conv_pkg;

    localparam int unsigned DATA_W             = 16;
    localparam int unsigned DIGIT_W            = 4;
    localparam int unsigned DIGITS             = 4;
    localparam int unsigned STEP_W             = 5;
    localparam int unsigned CONV_STEPS_DEFAULT = 16;

    // Largest value that fits in four decimal digits.
    localparam logic [DATA_W-1:0] DEC_LIMIT   = 16'd9999;
    // Shown on all four digits when a decimal value does not fit.
    localparam logic [DATA_W-1:0] OVF_PATTERN = 16'hEEEE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DIGITS-1:0] point;
    } disp_t;

endpackage : seg_bcd_conv_pkg

// File: rtl/seg_bcd_conv_bcd_add3.sv
// Double-dabble digit adjust: adds 3 to a BCD digit that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   digit    - 4-bit BCD digit before adjust
//   adjusted - 4-bit digit after adjust (purely combinational)
module bcd_add3
    import seg_bcd_conv_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= DIGIT_W'(5)) begin
            adjusted = DIGIT_W'(digit + DIGIT_W'(3));
        end
    end

endmodule : bcd_add3

// File: rtl/seg_bcd_conv.sv
// Seven-segment display front end: accepts MMIO writes and presents four
// display nibbles plus decimal points. Hex writes pass straight through;
// decimal writes are converted to BCD by a sequential double-dabble engine.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   wr_en     - one-cycle write strobe (accepted only when idle)
//   wr_data   - raw hex nibbles or unsigned binary value
//   mode      - 0 = hex pass-through, 1 = decimal conversion
//   dp_in     - decimal-point request per digit
//   hex_data  - registered display nibbles, [3:0] is rightmost digit
//   hex_point - registered decimal-point enables
//   busy      - high while a decimal conversion is running
//   done      - one-cycle pulse when the display registers update
module seg_bcd_conv
    import seg_bcd_conv_pkg::*;
#(
    parameter int unsigned CONV_STEPS = CONV_STEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mode,
    input  logic [DIGITS-1:0] dp_in,
    output logic [DATA_W-1:0] hex_data,
    output logic [DIGITS-1:0] hex_point,
    output logic              busy,
    output logic              done
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CONV_STEPS - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [DATA_W-1:0] bin_q,   bin_d;
    logic [DATA_W-1:0] bcd_q,   bcd_d;
    logic [DIGITS-1:0] dp_q,    dp_d;
    disp_t             disp_q,  disp_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [DATA_W-1:0] bcd_adj;
    logic              dec_fits;

    assign dec_fits = (wr_data <= DEC_LIMIT);

    // One add-3 adjust per BCD digit of the accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (bcd_q  [g*DIGIT_W +: DIGIT_W]),
            .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en && mode && dec_fits) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (step_q == LAST_STEP) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; writes outside IDLE fall through untouched.
    always_comb begin
        step_d = step_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        dp_d   = dp_q;
        disp_d = disp_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    if (!mode) begin
                        disp_d = '{data: wr_data, point: dp_in};
                        done_d = 1'b1;
                    end else if (!dec_fits) begin
                        disp_d = '{data: OVF_PATTERN, point: '0};
                        done_d = 1'b1;
                    end else begin
                        bin_d  = wr_data;
                        bcd_d  = '0;
                        dp_d   = dp_in;
                        step_d = '0;
                        busy_d = 1'b1;
                    end
                end
            end
            ST_CONV: begin
                // Adjust then shift {bcd, bin} left by one.
                bcd_d  = {bcd_adj[DATA_W-2:0], bin_q[DATA_W-1]};
                bin_d  = {bin_q[DATA_W-2:0], 1'b0};
                step_d = STEP_W'(step_q + STEP_W'(1));
            end
            ST_LOAD: begin
                disp_d = '{data: bcd_q, point: dp_q};
                done_d = 1'b1;
                busy_d = 1'b0;
                step_d = '0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign hex_data  = disp_q.data;
    assign hex_point = disp_q.point;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : seg_bcd_conv
